// File: rtl/maxnet_controller.sv
// MaxNet controller: sequences memory load, X-register seeding and the
// PU feedback loop of the 4-lane MaxNet datapath. It stops when the
// datapath reports convergence (finish) or when the iteration limit is hit.
module maxnet_controller #(
  parameter int PU_LATENCY = 2,
  parameter int MAX_ITER   = 255,
  parameter int ITER_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  output logic              sel,
  output logic              ld_memory,
  output logic              ld_reg,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_INIT   = 3'd2,
    S_WAIT   = 3'd3,
    S_CHECK  = 3'd4,
    S_UPDATE = 3'd5,
    S_DONE   = 3'd6,
    S_FAIL   = 3'd7
  } state_t;

  // PU_LATENCY is at most 15, so four bits cover every wait count.
  localparam logic [3:0]        WAIT_LAST = 4'(PU_LATENCY - 1);
  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      iter_q     <= iter_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    iter_d     = iter_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Clearing on the way into INIT means the INIT cycle already shows
        // a count of 0 for the new run. INIT clears again below.
        iter_d     = '0;
        wait_cnt_d = '0;
        state_d    = S_INIT;
      end
      S_INIT: begin
        iter_d     = '0;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        // Convergence wins over the limit check on the same cycle.
        if (finish)                 state_d = S_DONE;
        else if (iter_q == ITER_MAX) state_d = S_FAIL;
        else                        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        // UPDATE is only reached below the limit. Saturation keeps the
        // counter from wrapping even if that ever changes.
        if (iter_q != ITER_MAX) iter_d = iter_q + 1'b1;
        state_d = S_WAIT;
      end
      S_DONE, S_FAIL: begin
        if (start) state_d = S_LOAD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from the state register only.
  always_comb begin
    sel       = 1'b0;
    ld_memory = 1'b0;
    ld_reg    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_memory = 1'b1;
        busy      = 1'b1;
      end
      S_INIT: begin
        sel    = 1'b1;
        ld_reg = 1'b1;
        busy   = 1'b1;
      end
      S_WAIT, S_CHECK: begin
        busy = 1'b1;
      end
      S_UPDATE: begin
        ld_reg = 1'b1;
        busy   = 1'b1;
      end
      S_DONE:  done    = 1'b1;
      S_FAIL:  timeout = 1'b1;
      default: begin
      end
    endcase
  end

  assign iter_count = iter_q;

endmodule
